// File: rtl/vend_ctrl_if.sv
// Coin/selection front-end bundle and display/vend outputs of the vending sequencer.
// The front end drives through master; the sequencer itself connects through slave.
interface vend_ctrl_if;
  logic        coin_valid;
  logic [1:0]  coin_value;
  logic        sel_valid;
  logic [1:0]  sel_item;
  logic [10:0] credit;
  logic        redlight;
  logic        dispense;
  logic [1:0]  item_out;
  logic        change_valid;
  logic [10:0] change_amt;
  logic        coin_reject;
  logic        busy;

  modport master (
    output coin_valid, coin_value, sel_valid, sel_item,
    input  credit, redlight, dispense, item_out,
    input  change_valid, change_amt, coin_reject, busy
  );

  modport slave (
    input  coin_valid, coin_value, sel_valid, sel_item,
    output credit, redlight, dispense, item_out,
    output change_valid, change_amt, coin_reject, busy
  );
endinterface

// File: rtl/vend_ctrl.sv
// Vending-machine sequencer: accumulates credit, vends priced items, returns change
// and flags rejected actions. Every output comes straight from a register.
module vend_ctrl #(
  parameter int PRICE_A    = 5,
  parameter int PRICE_B    = 8,
  parameter int PRICE_C    = 12,
  parameter int MAX_CREDIT = 15,
  parameter int HOLD       = 4,
  parameter int TIMEOUT    = 1000
) (
  input logic         clk,
  input logic         rst,
  vend_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_DISPENSE,
    S_CHANGE,
    S_DENY
  } state_t;

  localparam int HCW = $clog2(HOLD + 1);
  localparam int ICW = $clog2(TIMEOUT);

  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD - 1);
  localparam logic [HCW-1:0] HOLD_END  = HCW'(HOLD);
  localparam logic [ICW-1:0] IDLE_LAST = ICW'(TIMEOUT - 1);
  localparam logic [10:0]    P_A       = 11'(PRICE_A);
  localparam logic [10:0]    P_B       = 11'(PRICE_B);
  localparam logic [10:0]    P_C       = 11'(PRICE_C);
  localparam logic [11:0]    MAX_C     = 12'(MAX_CREDIT);

  state_t         r_state,       w_state;
  logic [10:0]    r_credit,      w_credit;
  logic           r_redlight,    w_redlight;
  logic           r_dispense,    w_dispense;
  logic [1:0]     r_itemOut,     w_itemOut;
  logic           r_changeValid, w_changeValid;
  logic [10:0]    r_changeAmt,   w_changeAmt;
  logic           r_coinReject,  w_coinReject;
  logic           r_busy,        w_busy;
  logic [HCW-1:0] r_holdCnt,     w_holdCnt;
  logic [ICW-1:0] r_idleCnt,     w_idleCnt;

  logic [10:0] w_coinUnits;
  logic [10:0] w_price;
  logic [11:0] w_sum;

  always_comb begin
    w_coinUnits = 11'd1;
    case (bus.coin_value)
      2'b00:   w_coinUnits = 11'd1;
      2'b01:   w_coinUnits = 11'd2;
      2'b10:   w_coinUnits = 11'd5;
      default: w_coinUnits = 11'd10;
    endcase
  end

  always_comb begin
    w_price = '0;
    case (bus.sel_item)
      2'd0:    w_price = P_A;
      2'd1:    w_price = P_B;
      2'd2:    w_price = P_C;
      default: w_price = '0;
    endcase
  end

  // One extra bit so the overflow comparison can never wrap.
  assign w_sum = {1'b0, r_credit} + {1'b0, w_coinUnits};

  always_comb begin
    w_state       = r_state;
    w_credit      = r_credit;
    w_itemOut     = r_itemOut;
    w_holdCnt     = r_holdCnt;
    w_idleCnt     = r_idleCnt;
    w_dispense    = 1'b0;
    w_redlight    = 1'b0;
    w_changeValid = 1'b0;
    w_changeAmt   = '0;
    w_coinReject  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.coin_valid) begin
          w_credit  = w_coinUnits;
          w_idleCnt = '0;
          w_state   = S_COLLECT;
        end
      end

      S_COLLECT: begin
        if (bus.coin_valid) begin
          if (w_sum <= MAX_C) begin
            w_credit = w_sum[10:0];
          end else begin
            w_coinReject = 1'b1;
          end
          w_idleCnt = '0;
        end else if (bus.sel_valid) begin
          if (bus.sel_item == 2'd3) begin
            w_state       = S_CHANGE;
            w_changeValid = (r_credit != '0);
            w_changeAmt   = r_credit;
          end else if (w_price <= r_credit) begin
            w_credit   = r_credit - w_price;
            w_itemOut  = bus.sel_item;
            w_holdCnt  = '0;
            w_dispense = 1'b1;
            w_state    = S_DISPENSE;
          end else begin
            w_holdCnt  = '0;
            w_redlight = 1'b1;
            w_state    = S_DENY;
          end
        end else if (r_idleCnt == IDLE_LAST) begin
          w_state       = S_CHANGE;
          w_changeValid = (r_credit != '0);
          w_changeAmt   = r_credit;
        end else begin
          w_idleCnt = r_idleCnt + ICW'(1);
        end
      end

      // The strobe covers the first HOLD cycles; one more cycle passes before CHANGE.
      S_DISPENSE: begin
        w_coinReject = bus.coin_valid;
        if (r_holdCnt == HOLD_END) begin
          w_state       = S_CHANGE;
          w_changeValid = (r_credit != '0);
          w_changeAmt   = r_credit;
        end else begin
          w_holdCnt  = r_holdCnt + HCW'(1);
          w_dispense = (r_holdCnt < HOLD_LAST);
        end
      end

      S_CHANGE: begin
        w_coinReject = bus.coin_valid;
        w_credit     = '0;
        w_state      = S_IDLE;
      end

      S_DENY: begin
        w_coinReject = bus.coin_valid;
        if (r_holdCnt == HOLD_LAST) begin
          w_idleCnt = '0;
          w_state   = S_COLLECT;
        end else begin
          w_holdCnt  = r_holdCnt + HCW'(1);
          w_redlight = 1'b1;
        end
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase

    w_busy = (w_state == S_DISPENSE) || (w_state == S_CHANGE) || (w_state == S_DENY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_credit      <= '0;
      r_redlight    <= 1'b0;
      r_dispense    <= 1'b0;
      r_itemOut     <= '0;
      r_changeValid <= 1'b0;
      r_changeAmt   <= '0;
      r_coinReject  <= 1'b0;
      r_busy        <= 1'b0;
      r_holdCnt     <= '0;
      r_idleCnt     <= '0;
    end else begin
      r_state       <= w_state;
      r_credit      <= w_credit;
      r_redlight    <= w_redlight;
      r_dispense    <= w_dispense;
      r_itemOut     <= w_itemOut;
      r_changeValid <= w_changeValid;
      r_changeAmt   <= w_changeAmt;
      r_coinReject  <= w_coinReject;
      r_busy        <= w_busy;
      r_holdCnt     <= w_holdCnt;
      r_idleCnt     <= w_idleCnt;
    end
  end

  assign bus.credit       = r_credit;
  assign bus.redlight     = r_redlight;
  assign bus.dispense     = r_dispense;
  assign bus.item_out     = r_itemOut;
  assign bus.change_valid = r_changeValid;
  assign bus.change_amt   = r_changeAmt;
  assign bus.coin_reject  = r_coinReject;
  assign bus.busy         = r_busy;

endmodule

// File: tb/tb_vend_ctrl.sv
// Scoreboard bench for vend_ctrl: a transaction-level machine model schedules the
// output events each stimulus should cause; a negedge monitor matches what the DUT shows.
module tb_vend_ctrl;
  localparam int PRICE_A    = 5;
  localparam int PRICE_B    = 8;
  localparam int PRICE_C    = 12;
  localparam int MAX_CREDIT = 15;
  localparam int HOLD       = 4;
  localparam int TIMEOUT    = 1000;

  localparam int K_CRED = 0;
  localparam int K_REJ  = 1;
  localparam int K_DON  = 2;
  localparam int K_DOFF = 3;
  localparam int K_RON  = 4;
  localparam int K_ROFF = 5;
  localparam int K_CHG  = 6;
  localparam int K_BON  = 7;
  localparam int K_BOFF = 8;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } expEvt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   nChecks = 0;
  int   nBad = 0;

  expEvt_t expQ[$];

  int mMode = 0;
  int mCredit = 0;
  int mBusyEnd = 0;
  int mAfterBusy = 0;
  int mLastAct = 0;

  int prevCredit = 0;
  bit prevDisp = 1'b0;
  bit prevRed = 1'b0;
  bit prevBusy = 1'b0;

  vend_ctrl_if bus();

  vend_ctrl #(
    .PRICE_A(PRICE_A), .PRICE_B(PRICE_B), .PRICE_C(PRICE_C),
    .MAX_CREDIT(MAX_CREDIT), .HOLD(HOLD), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  function automatic string kindName(int k);
    case (k)
      K_CRED:  return "credit";
      K_REJ:   return "coin_reject";
      K_DON:   return "dispense_on";
      K_DOFF:  return "dispense_off";
      K_RON:   return "redlight_on";
      K_ROFF:  return "redlight_off";
      K_CHG:   return "change";
      K_BON:   return "busy_on";
      K_BOFF:  return "busy_off";
      default: return "none";
    endcase
  endfunction

  function automatic int coinUnits(logic [1:0] c);
    case (c)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 5;
      default: return 10;
    endcase
  endfunction

  function automatic int priceOf(logic [1:0] item);
    case (item)
      2'd0:    return PRICE_A;
      2'd1:    return PRICE_B;
      default: return PRICE_C;
    endcase
  endfunction

  task automatic pushExp(int c, int k, int v);
    expEvt_t e;
    int idx;
    e.cyc = c;
    e.kind = k;
    e.val = v;
    idx = expQ.size();
    for (int i = 0; i < expQ.size(); i++) begin
      if (expQ[i].cyc * 16 + expQ[i].kind > c * 16 + k) begin
        idx = i;
        break;
      end
    end
    expQ.insert(idx, e);
  endtask

  task automatic modelRefund(int t);
    if (mCredit > 0) begin
      pushExp(t, K_CHG, mCredit);
      pushExp(t + 1, K_CRED, 0);
    end
    pushExp(t, K_BON, 0);
    pushExp(t + 1, K_BOFF, 0);
    mCredit = 0;
    mMode = 2;
    mBusyEnd = t + 2;
    mAfterBusy = 0;
  endtask

  // Modes: 0 idle, 1 collecting, 2 occupied until mBusyEnd, then mAfterBusy.
  task automatic modelEdge(int t, bit coin, logic [1:0] cv, bit sel, logic [1:0] item);
    int u;
    int p;
    u = coinUnits(cv);
    if (mMode == 2 && t >= mBusyEnd) mMode = mAfterBusy;
    if (mMode == 2) begin
      if (coin) pushExp(t, K_REJ, 0);
    end else if (mMode == 0) begin
      if (coin) begin
        mCredit = u;
        pushExp(t, K_CRED, mCredit);
        mMode = 1;
        mLastAct = t;
      end
    end else if (coin) begin
      if (mCredit + u <= MAX_CREDIT) begin
        mCredit = mCredit + u;
        pushExp(t, K_CRED, mCredit);
      end else begin
        pushExp(t, K_REJ, 0);
      end
      mLastAct = t;
    end else if (sel) begin
      p = priceOf(item);
      if (item == 2'd3) begin
        modelRefund(t);
      end else if (p <= mCredit) begin
        mCredit = mCredit - p;
        pushExp(t, K_CRED, mCredit);
        pushExp(t, K_DON, int'(item));
        pushExp(t, K_BON, 0);
        pushExp(t + HOLD, K_DOFF, 0);
        if (mCredit > 0) begin
          pushExp(t + HOLD + 1, K_CHG, mCredit);
          pushExp(t + HOLD + 2, K_CRED, 0);
        end
        pushExp(t + HOLD + 2, K_BOFF, 0);
        mCredit = 0;
        mMode = 2;
        mBusyEnd = t + HOLD + 3;
        mAfterBusy = 0;
      end else begin
        pushExp(t, K_RON, 0);
        pushExp(t, K_BON, 0);
        pushExp(t + HOLD, K_ROFF, 0);
        pushExp(t + HOLD, K_BOFF, 0);
        mMode = 2;
        mBusyEnd = t + HOLD + 1;
        mAfterBusy = 1;
        mLastAct = t + HOLD;
      end
    end else if (t - mLastAct >= TIMEOUT) begin
      modelRefund(t);
    end
  endtask

  task automatic checkValue(string name, int act, int exp);
    nChecks++;
    if (act != exp) begin
      nBad++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic checkOutput(int kind, int val);
    expEvt_t e;
    nChecks++;
    if (expQ.size() == 0) begin
      nBad++;
      $display("[TB] FAIL %s at cycle %0d: got unexpected event val=%0d, expected nothing",
               kindName(kind), cyc, val);
    end else begin
      e = expQ.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.val != val) begin
        nBad++;
        $display("[TB] FAIL %s at cycle %0d: got %s val=%0d, expected %s val=%0d at cycle %0d",
                 kindName(kind), cyc, kindName(kind), val, kindName(e.kind), e.val, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prevCredit = 0;
      prevDisp = 1'b0;
      prevRed = 1'b0;
      prevBusy = 1'b0;
    end else begin
      while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
        nChecks++;
        nBad++;
        $display("[TB] FAIL %s missed: got nothing by cycle %0d, expected val=%0d at cycle %0d",
                 kindName(expQ[0].kind), cyc, expQ[0].val, expQ[0].cyc);
        void'(expQ.pop_front());
      end
      if (int'(bus.credit) != prevCredit) checkOutput(K_CRED, int'(bus.credit));
      if (bus.coin_reject) checkOutput(K_REJ, 0);
      if (bus.dispense && !prevDisp) checkOutput(K_DON, int'(bus.item_out));
      if (!bus.dispense && prevDisp) checkOutput(K_DOFF, 0);
      if (bus.redlight && !prevRed) checkOutput(K_RON, 0);
      if (!bus.redlight && prevRed) checkOutput(K_ROFF, 0);
      if (bus.change_valid) checkOutput(K_CHG, int'(bus.change_amt));
      if (bus.busy && !prevBusy) checkOutput(K_BON, 0);
      if (!bus.busy && prevBusy) checkOutput(K_BOFF, 0);
      checkValue("dispense_redlight_overlap", int'(bus.dispense & bus.redlight), 0);
      if (!bus.change_valid) checkValue("change_amt_idle", int'(bus.change_amt), 0);
      prevCredit = int'(bus.credit);
      prevDisp = bus.dispense;
      prevRed = bus.redlight;
      prevBusy = bus.busy;
    end
  end

  task automatic applyStimulus(bit coin, logic [1:0] cv, bit sel, logic [1:0] item);
    bus.coin_valid = coin;
    bus.coin_value = cv;
    bus.sel_valid = sel;
    bus.sel_item = item;
    modelEdge(cyc + 1, coin, cv, sel, item);
    @(posedge clk);
    #1;
    bus.coin_valid = 1'b0;
    bus.sel_valid = 1'b0;
  endtask

  task automatic idleCycles(int n);
    repeat (n) applyStimulus(1'b0, 2'b00, 1'b0, 2'd0);
  endtask

  task automatic checkResetOutputs(string tag);
    checkValue({tag, "_credit"}, int'(bus.credit), 0);
    checkValue({tag, "_redlight"}, int'(bus.redlight), 0);
    checkValue({tag, "_dispense"}, int'(bus.dispense), 0);
    checkValue({tag, "_item_out"}, int'(bus.item_out), 0);
    checkValue({tag, "_change_valid"}, int'(bus.change_valid), 0);
    checkValue({tag, "_change_amt"}, int'(bus.change_amt), 0);
    checkValue({tag, "_coin_reject"}, int'(bus.coin_reject), 0);
    checkValue({tag, "_busy"}, int'(bus.busy), 0);
  endtask

  initial begin
    bus.coin_valid = 1'b0;
    bus.coin_value = 2'b00;
    bus.sel_valid = 1'b0;
    bus.sel_item = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst = 1'b0;

    $display("[TB] purchase with change");
    applyStimulus(1'b1, 2'b10, 1'b0, 2'd0);
    applyStimulus(1'b1, 2'b10, 1'b0, 2'd0);
    applyStimulus(1'b0, 2'b00, 1'b1, 2'd1);
    idleCycles(HOLD + 4);

    $display("[TB] denied purchase then top-up");
    applyStimulus(1'b1, 2'b10, 1'b0, 2'd0);
    applyStimulus(1'b0, 2'b00, 1'b1, 2'd2);
    idleCycles(HOLD + 1);
    applyStimulus(1'b1, 2'b11, 1'b0, 2'd0);
    applyStimulus(1'b0, 2'b00, 1'b1, 2'd3);
    idleCycles(3);

    $display("[TB] overflow rejects");
    applyStimulus(1'b1, 2'b11, 1'b0, 2'd0);
    applyStimulus(1'b1, 2'b11, 1'b0, 2'd0);
    applyStimulus(1'b1, 2'b10, 1'b0, 2'd0);
    applyStimulus(1'b1, 2'b00, 1'b0, 2'd0);
    applyStimulus(1'b0, 2'b00, 1'b1, 2'd3);
    idleCycles(3);

    $display("[TB] cancel");
    applyStimulus(1'b1, 2'b01, 1'b0, 2'd0);
    applyStimulus(1'b1, 2'b00, 1'b0, 2'd0);
    applyStimulus(1'b0, 2'b00, 1'b1, 2'd3);
    idleCycles(3);

    $display("[TB] idle timeout");
    applyStimulus(1'b1, 2'b00, 1'b0, 2'd0);
    idleCycles(TIMEOUT + 5);

    $display("[TB] coin and selection together");
    applyStimulus(1'b1, 2'b10, 1'b0, 2'd0);
    applyStimulus(1'b1, 2'b01, 1'b1, 2'd0);
    idleCycles(2);
    applyStimulus(1'b0, 2'b00, 1'b1, 2'd3);
    idleCycles(3);

    $display("[TB] coins while busy");
    applyStimulus(1'b1, 2'b11, 1'b0, 2'd0);
    applyStimulus(1'b0, 2'b00, 1'b1, 2'd0);
    repeat (HOLD + 3) applyStimulus(1'b1, 2'b00, 1'b1, 2'd1);
    idleCycles(3);

    $display("[TB] reset during dispense");
    applyStimulus(1'b1, 2'b10, 1'b0, 2'd0);
    applyStimulus(1'b1, 2'b10, 1'b0, 2'd0);
    applyStimulus(1'b0, 2'b00, 1'b1, 2'd1);
    idleCycles(2);
    #2;
    rst = 1'b1;
    #1;
    checkResetOutputs("async_reset");
    expQ.delete();
    mMode = 0;
    mCredit = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idleCycles(HOLD + 5);

    $display("[TB] random traffic");
    for (int n = 0; n < 2500; n++) begin
      int r;
      bit c;
      bit s;
      r = $urandom_range(99);
      c = (r < 40) || (r >= 95);
      s = ((r >= 40) && (r < 60)) || (r >= 95);
      applyStimulus(c, 2'($urandom_range(3)), s, 2'($urandom_range(3)));
    end
    idleCycles(30);

    checkValue("pending_events", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule
